// File: rtl/led_blink_multi.sv
// ---------------------------------------------------------------------------
// led_blink_multi
// NCH independent LED blink channels. Each channel is armed by a tick while
// idle and then plays one of three patterns, selected by the mode latched at
// trigger time:
//   0/3 : one-shot, a single ON_CYC-long pulse
//   1   : retrigger, a tick during ON restarts the ON_CYC window
//   2   : burst, BURST_N pulses of ON_CYC separated by OFF_CYC gaps
//
// Ports
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset
//   tick  : [NCH]     per-channel trigger, sampled every cycle
//   mode  : [2*NCH]   per-channel mode, bits [2i+1:2i] for channel i
//   blink : [NCH]     registered LED drive, high = on
//   busy  : [NCH]     registered, high while the channel is not idle
// ---------------------------------------------------------------------------
module led_blink_multi #(
   parameter int unsigned NCH     = 4,
   parameter int unsigned CW      = 24,
   parameter int unsigned ON_CYC  = 10_000_000,
   parameter int unsigned OFF_CYC = 10_000_000,
   parameter int unsigned BURST_N = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [NCH-1:0]   tick,
   input  logic [2*NCH-1:0] mode,
   output logic [NCH-1:0]   blink,
   output logic [NCH-1:0]   busy
);

   localparam int unsigned PW = $clog2(BURST_N + 1);

   localparam logic [CW-1:0] ON_LAST   = CW'(ON_CYC - 1);
   localparam logic [CW-1:0] OFF_LAST  = CW'(OFF_CYC - 1);
   localparam logic [PW-1:0] PULSE_MAX = PW'(BURST_N);

   localparam logic [1:0] MODE_RETRIG = 2'd1;
   localparam logic [1:0] MODE_BURST  = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ON   = 2'd1,
      ST_OFF  = 2'd2
   } state_t;

   state_t        state_q [NCH];
   state_t        state_d [NCH];
   logic [CW-1:0] phase_q [NCH];
   logic [CW-1:0] phase_d [NCH];
   logic [PW-1:0] pulse_q [NCH];
   logic [PW-1:0] pulse_d [NCH];
   logic [1:0]    mode_q  [NCH];
   logic [1:0]    mode_d  [NCH];

   // State, counters, latched modes and output flops
   always_ff @(posedge clk) begin
      for (int i = 0; i < int'(NCH); i++) begin
         if (rst) begin
            state_q[i] <= ST_IDLE;
            phase_q[i] <= '0;
            pulse_q[i] <= '0;
            mode_q[i]  <= '0;
            blink[i]   <= 1'b0;
            busy[i]    <= 1'b0;
         end else begin
            state_q[i] <= state_d[i];
            phase_q[i] <= phase_d[i];
            pulse_q[i] <= pulse_d[i];
            mode_q[i]  <= mode_d[i];
            // Outputs mirror the next state so they align with it in the same cycle
            blink[i]   <= (state_d[i] == ST_ON);
            busy[i]    <= (state_d[i] != ST_IDLE);
         end
      end
   end

   // Per-channel next-state and counter logic
   always_comb begin
      for (int i = 0; i < int'(NCH); i++) begin
         state_d[i] = state_q[i];
         phase_d[i] = phase_q[i];
         pulse_d[i] = pulse_q[i];
         mode_d[i]  = mode_q[i];

         case (state_q[i])
            ST_IDLE: begin
               if (tick[i]) begin
                  state_d[i] = ST_ON;
                  phase_d[i] = '0;
                  pulse_d[i] = '0;
                  mode_d[i]  = mode[2*i +: 2];
               end
            end

            ST_ON: begin
               if (tick[i] && (mode_q[i] == MODE_RETRIG)) begin
                  // Reload wins over expiry so the pulse never drops for a cycle
                  phase_d[i] = '0;
               end else if (phase_q[i] == ON_LAST) begin
                  phase_d[i] = '0;
                  pulse_d[i] = (pulse_q[i] == PULSE_MAX) ? pulse_q[i]
                                                         : pulse_q[i] + PW'(1);
                  if ((mode_q[i] == MODE_BURST) && (pulse_d[i] < PULSE_MAX)) begin
                     state_d[i] = ST_OFF;
                  end else begin
                     state_d[i] = ST_IDLE;
                  end
               end else begin
                  phase_d[i] = phase_q[i] + CW'(1);
               end
            end

            ST_OFF: begin
               if (phase_q[i] == OFF_LAST) begin
                  phase_d[i] = '0;
                  state_d[i] = ST_ON;
               end else begin
                  phase_d[i] = phase_q[i] + CW'(1);
               end
            end

            default: begin
               state_d[i] = ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_led_blink_multi.sv
// ---------------------------------------------------------------------------
// tb_led_blink_multi
// Directed vector tables for the documented scenarios, a held-tick sequence
// for the back-to-back gap, then random stimulus against a countdown model.
// ---------------------------------------------------------------------------
module tb_led_blink_multi;

   localparam int NCH     = 4;
   localparam int CW      = 8;
   localparam int ON_CYC  = 4;
   localparam int OFF_CYC = 3;
   localparam int BURST_N = 2;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] tick;
   logic [7:0] mode;
   logic [3:0] blink;
   logic [3:0] busy;

   always #5 clk = ~clk;

   led_blink_multi #(
      .NCH     (NCH),
      .CW      (CW),
      .ON_CYC  (ON_CYC),
      .OFF_CYC (OFF_CYC),
      .BURST_N (BURST_N)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .tick  (tick),
      .mode  (mode),
      .blink (blink),
      .busy  (busy)
   );

   typedef struct {
      logic       rst;
      logic [3:0] tick;
      logic [7:0] mode;
      logic [3:0] exp_blink;
      logic [3:0] exp_busy;
   } vec_t;

   vec_t vecs_a[$];
   vec_t vecs_b[$];

   int n_vec = 0;
   int n_bad = 0;

   // Reference model: remaining cycles of the current ON / OFF phase and
   // number of ON phases still owed
   int         on_left     [NCH];
   int         off_left    [NCH];
   int         pulses_left [NCH];
   logic [1:0] m_mode      [NCH];

   task automatic model_step(input logic r, input logic [3:0] t, input logic [7:0] m);
      for (int c = 0; c < NCH; c++) begin
         if (r) begin
            on_left[c] = 0; off_left[c] = 0; pulses_left[c] = 0; m_mode[c] = 2'd0;
         end else if (on_left[c] == 0 && off_left[c] == 0) begin
            if (t[c]) begin
               m_mode[c]      = m[2*c +: 2];
               on_left[c]     = ON_CYC;
               pulses_left[c] = (m_mode[c] == 2'd2) ? BURST_N : 1;
            end
         end else if (on_left[c] > 0) begin
            if (m_mode[c] == 2'd1 && t[c]) begin
               on_left[c] = ON_CYC;
            end else begin
               on_left[c] = on_left[c] - 1;
               if (on_left[c] == 0) begin
                  pulses_left[c] = pulses_left[c] - 1;
                  if (pulses_left[c] > 0) off_left[c] = OFF_CYC;
               end
            end
         end else begin
            off_left[c] = off_left[c] - 1;
            if (off_left[c] == 0) on_left[c] = ON_CYC;
         end
      end
   endtask

   task automatic model_out(output logic [3:0] eb, output logic [3:0] ey);
      for (int c = 0; c < NCH; c++) begin
         eb[c] = (on_left[c] > 0);
         ey[c] = (on_left[c] > 0) || (off_left[c] > 0);
      end
   endtask

   // Drive inputs for one edge, then land on the following falling edge
   task automatic apply(input logic r, input logic [3:0] t, input logic [7:0] m);
      rst  = r;
      tick = t;
      mode = m;
      @(posedge clk);
      model_step(r, t, m);
      @(negedge clk);
   endtask

   task automatic check(input string name, input logic [3:0] eb, input logic [3:0] ey);
      n_vec++;
      if (blink !== eb || busy !== ey) begin
         n_bad++;
         $display("FAIL %s: got blink=%b busy=%b, expected blink=%b busy=%b",
                  name, blink, busy, eb, ey);
      end
   endtask

   task automatic add(inout vec_t q[$], input logic r, input logic [3:0] t,
                      input logic [7:0] m, input logic [3:0] eb, input logic [3:0] ey);
      vec_t v;
      v.rst = r; v.tick = t; v.mode = m; v.exp_blink = eb; v.exp_busy = ey;
      q.push_back(v);
   endtask

   initial begin
      logic [3:0] eb, ey, t;
      logic [7:0] m;
      logic       r;

      // Scenario A: ch0 one-shot (mode changed mid-pulse, then retriggered),
      // ch1 retrigger, ch2 burst with an ignored tick in the gap
      for (int k = 0; k < 24; k++) begin
         t  = 4'b0000;
         if (k == 10) t = 4'b0111;
         if (k == 12) t = 4'b0001;
         if (k == 13) t = 4'b0010;
         if (k == 16) t = 4'b0101;
         if (k == 18) t = 4'b0001;
         m  = (k >= 12) ? 8'h25 : 8'h24;
         eb = 4'b0000; ey = 4'b0000;
         if (k >= 10 && k <= 13) begin eb = 4'b0111; ey = 4'b0111; end
         if (k == 14 || k == 15) begin eb = 4'b0010; ey = 4'b0110; end
         if (k == 16)            begin eb = 4'b0011; ey = 4'b0111; end
         if (k >= 17 && k <= 20) begin eb = 4'b0101; ey = 4'b0101; end
         if (k == 21)            begin eb = 4'b0001; ey = 4'b0001; end
         add(vecs_a, 1'b0, t, m, eb, ey);
      end

      // Scenario B: all four channels at once (modes 0/1/2/3), reset in the
      // middle of the ch2 gap with a tick held during reset, then a fresh burst
      for (int j = 0; j < 25; j++) begin
         r  = (j == 0 || j == 9);
         t  = 4'b0000;
         if (j == 3)  t = 4'b1111;
         if (j == 9)  t = 4'b0001;
         if (j == 13) t = 4'b0100;
         eb = 4'b0000; ey = 4'b0000;
         if (j >= 3 && j <= 6)   begin eb = 4'b1111; ey = 4'b1111; end
         if (j == 7 || j == 8)   begin eb = 4'b0000; ey = 4'b0100; end
         if (j >= 13 && j <= 16) begin eb = 4'b0100; ey = 4'b0100; end
         if (j >= 17 && j <= 19) begin eb = 4'b0000; ey = 4'b0100; end
         if (j >= 20 && j <= 23) begin eb = 4'b0100; ey = 4'b0100; end
         add(vecs_b, r, t, 8'hE4, eb, ey);
      end

      rst = 1'b1; tick = '0; mode = '0;
      @(negedge clk);
      apply(1'b1, 4'b0000, 8'h00);
      apply(1'b1, 4'b1111, 8'h00);
      check("reset", 4'b0000, 4'b0000);

      foreach (vecs_a[k]) begin
         apply(vecs_a[k].rst, vecs_a[k].tick, vecs_a[k].mode);
         check($sformatf("tabA[%0d]", k), vecs_a[k].exp_blink, vecs_a[k].exp_busy);
      end

      foreach (vecs_b[j]) begin
         apply(vecs_b[j].rst, vecs_b[j].tick, vecs_b[j].mode);
         check($sformatf("tabB[%0d]", j), vecs_b[j].exp_blink, vecs_b[j].exp_busy);
      end

      // Tick held high on ch0 in one-shot mode: 4 on, 1 off, repeating
      apply(1'b1, 4'b0000, 8'h00);
      for (int j = 0; j < 12; j++) begin
         apply(1'b0, 4'b0001, 8'h00);
         eb = {3'b000, ((j % 5) != 4)};
         check($sformatf("held[%0d]", j), eb, eb);
      end

      // Random stimulus against the model
      apply(1'b1, 4'b0000, 8'h00);
      for (int n = 0; n < 3000; n++) begin
         r = ($urandom_range(0, 199) == 0);
         for (int c = 0; c < NCH; c++) t[c] = ($urandom_range(0, 5) == 0);
         m = 8'($urandom);
         apply(r, t, m);
         model_out(eb, ey);
         check($sformatf("rand[%0d]", n), eb, ey);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
